// File: rtl/trigger_level_controller_if.sv
// Front-panel / display side bundle for the trigger level controller.
// Latency: none (signal bundle only).
// Backpressure: none; buttons and vsync are free-running levels, outputs are registered.
// Signals: btnUp/btnDown/btnCenter (debounced, clock-synchronous buttons), vsync (frame
//          timing), level (committed signed level), levelUpdated (change pulse),
//          atMin/atMax (target sits on a clamp limit).
interface trigger_level_controller_if #(
   parameter int DATA_IN_BITS = 12
);
   logic                           btnUp;
   logic                           btnDown;
   logic                           btnCenter;
   logic                           vsync;
   logic signed [DATA_IN_BITS-1:0] level;
   logic                           levelUpdated;
   logic                           atMin;
   logic                           atMax;

   // Panel / timing side: drives buttons and vsync, consumes the level.
   modport master (
      output btnUp, btnDown, btnCenter, vsync,
      input  level, levelUpdated, atMin, atMax
   );

   // Controller side.
   modport slave (
      input  btnUp, btnDown, btnCenter, vsync,
      output level, levelUpdated, atMin, atMax
   );
endinterface

// File: rtl/trigger_level_controller.sv
// Steps a clamped trigger level from up/down/center buttons with hold auto-repeat and
// acceleration; commits it downstream only on a vsync rising edge.
// Latency: press sampled at edge t steps target at t+1; level follows target on the vsync
// edge; atMin/atMax lag target by one cycle. Backpressure: none.
// Ports: clock, reset_n (async active-low), bus (slave modport: buttons, vsync in;
//        level, levelUpdated, atMin, atMax out).
module trigger_level_controller #(
   parameter int DATA_IN_BITS  = 12,
   parameter int LEVEL_MIN     = -384,
   parameter int LEVEL_MAX     = 383,
   parameter int LEVEL_RESET   = 0,
   parameter int HOLD_DELAY    = 25_000_000,
   parameter int REPEAT_PERIOD = 5_000_000,
   parameter int FAST_AFTER    = 8,
   parameter int STEP_FAST     = 8
) (
   input logic                      clock,
   input logic                      reset_n,
   trigger_level_controller_if.slave bus
);

   // Target carries one guard bit so a step past a limit is seen before clamping.
   localparam int TW      = DATA_IN_BITS + 1;
   localparam int CNT_MAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int REP_W   = (FAST_AFTER < 1) ? 1 : $clog2(FAST_AFTER + 1);

   localparam logic signed [TW-1:0] MIN_T   = TW'(LEVEL_MIN);
   localparam logic signed [TW-1:0] MAX_T   = TW'(LEVEL_MAX);
   localparam logic signed [TW-1:0] RESET_T = TW'(LEVEL_RESET);
   localparam logic signed [TW-1:0] FAST_T  = TW'(STEP_FAST);
   localparam logic signed [TW-1:0] ONE_T   = TW'(1);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_DELAY - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
   localparam logic [REP_W-1:0] FAST_N    = REP_W'(FAST_AFTER);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FIRST  = 2'd1,
      HOLD   = 2'd2,
      REPEAT = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      DIR_NONE = 2'd0,
      DIR_UP   = 2'd1,
      DIR_DOWN = 2'd2
   } dir_t;

   state_t                  state, state_next;
   dir_t                    dir_lat, dir_lat_next;
   dir_t                    dir_now;
   logic [CNT_W-1:0]        cnt, cnt_next;
   logic [REP_W-1:0]        rep, rep_next;
   logic                    step_en;
   logic                    step_big;

   logic signed [TW-1:0]    target;
   logic signed [TW-1:0]    step_mag;
   logic signed [TW-1:0]    step_sum;
   logic signed [TW-1:0]    target_stepped;

   logic                    vsync_prev;
   logic                    vsync_rise;
   logic signed [DATA_IN_BITS-1:0] level_q;
   logic                    updated_q;
   logic                    at_min_q;
   logic                    at_max_q;

   // Both buttons together resolve to no direction, which also ends a hold.
   always_comb begin
      dir_now = DIR_NONE;
      if (bus.btnUp && !bus.btnDown) begin
         dir_now = DIR_UP;
      end else if (bus.btnDown && !bus.btnUp) begin
         dir_now = DIR_DOWN;
      end
   end

   // ---------------------------------------------------------------- FSM state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         dir_lat <= DIR_NONE;
         cnt     <= '0;
         rep     <= '0;
      end else begin
         state   <= state_next;
         dir_lat <= dir_lat_next;
         cnt     <= cnt_next;
         rep     <= rep_next;
      end
   end

   // ---------------------------------------------------------------- FSM next state / step
   always_comb begin
      state_next   = state;
      dir_lat_next = dir_lat;
      cnt_next     = cnt;
      rep_next     = rep;
      step_en      = 1'b0;
      step_big     = 1'b0;

      if (bus.btnCenter) begin
         state_next   = IDLE;
         dir_lat_next = DIR_NONE;
         cnt_next     = '0;
         rep_next     = '0;
      end else begin
         case (state)
            IDLE: begin
               if (dir_now != DIR_NONE) begin
                  state_next   = FIRST;
                  dir_lat_next = dir_now;
               end
            end

            // The first step is unconditional, so a one-cycle tap still moves one code.
            FIRST: begin
               step_en    = 1'b1;
               cnt_next   = '0;
               state_next = HOLD;
            end

            HOLD: begin
               if (dir_now != dir_lat) begin
                  state_next = IDLE;
                  cnt_next   = '0;
                  rep_next   = '0;
               end else if (cnt == HOLD_LAST) begin
                  // The hold-expiry step is the first slow repeat step, so it
                  // already counts towards FAST_AFTER.
                  step_en    = 1'b1;
                  cnt_next   = '0;
                  rep_next   = REP_W'(1);
                  state_next = REPEAT;
               end else begin
                  cnt_next = cnt + CNT_W'(1);
               end
            end

            REPEAT: begin
               if (dir_now != dir_lat) begin
                  state_next = IDLE;
                  cnt_next   = '0;
                  rep_next   = '0;
               end else if (cnt == REP_LAST) begin
                  step_en  = 1'b1;
                  cnt_next = '0;
                  if (rep >= FAST_N) begin
                     step_big = 1'b1;
                  end else begin
                     rep_next = rep + REP_W'(1);
                  end
               end else begin
                  cnt_next = cnt + CNT_W'(1);
               end
            end

            default: begin
               state_next = IDLE;
               cnt_next   = '0;
               rep_next   = '0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------- step + clamp
   always_comb begin
      step_mag = step_big ? FAST_T : ONE_T;
      step_sum = (dir_lat == DIR_DOWN) ? (target - step_mag) : (target + step_mag);
      if (step_sum > MAX_T) begin
         target_stepped = MAX_T;
      end else if (step_sum < MIN_T) begin
         target_stepped = MIN_T;
      end else begin
         target_stepped = step_sum;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         target <= RESET_T;
      end else if (bus.btnCenter) begin
         target <= RESET_T;
      end else if (step_en) begin
         target <= target_stepped;
      end
   end

   // ---------------------------------------------------------------- frame commit
   // The commit takes target as it stands before this edge, so a coinciding step
   // only shows up at the next frame boundary.
   assign vsync_rise = bus.vsync && !vsync_prev;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         vsync_prev <= 1'b0;
         level_q    <= RESET_T[DATA_IN_BITS-1:0];
         updated_q  <= 1'b0;
         at_min_q   <= (RESET_T == MIN_T);
         at_max_q   <= (RESET_T == MAX_T);
      end else begin
         vsync_prev <= bus.vsync;
         at_min_q   <= (target == MIN_T);
         at_max_q   <= (target == MAX_T);
         if (vsync_rise) begin
            level_q   <= target[DATA_IN_BITS-1:0];
            updated_q <= (target[DATA_IN_BITS-1:0] != level_q);
         end else begin
            updated_q <= 1'b0;
         end
      end
   end

   assign bus.level        = level_q;
   assign bus.levelUpdated = updated_q;
   assign bus.atMin        = at_min_q;
   assign bus.atMax        = at_max_q;

endmodule

// File: tb/tb_trigger_level_controller.sv
// Directed bench for trigger_level_controller with short hold/repeat timing.
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: none.
module tb_trigger_level_controller;

   logic clock = 1'b0;
   logic reset_n;

   always #5 clock = ~clock;

   trigger_level_controller_if #(.DATA_IN_BITS(12)) tlc_if ();

   trigger_level_controller #(
      .DATA_IN_BITS  (12),
      .LEVEL_MIN     (-20),
      .LEVEL_MAX     (20),
      .LEVEL_RESET   (0),
      .HOLD_DELAY    (4),
      .REPEAT_PERIOD (2),
      .FAST_AFTER    (3),
      .STEP_FAST     (8)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (tlc_if.slave)
   );

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string tag, input int obs, input int exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   // One vsync pulse; returns the committed level and how many update pulses were seen.
   task automatic vsync_pulse(output int lvl, output int pulses);
      pulses = 0;
      tlc_if.vsync = 1'b1;
      cyc(1);
      lvl = int'(tlc_if.level);
      if (tlc_if.levelUpdated) pulses++;
      tlc_if.vsync = 1'b0;
      cyc(1);
      if (tlc_if.levelUpdated) pulses++;
   endtask

   // Target after each of the 20 edges of a held up press starting from 0.
   int hold_exp [20] = '{0, 1, 1, 1, 1, 2, 2, 3, 3, 4, 4, 12, 12, 20, 20, 20, 20, 20, 20, 20};

   initial begin
      int lvl;
      int pulses;

      reset_n          = 1'b1;
      tlc_if.btnUp     = 1'b0;
      tlc_if.btnDown   = 1'b0;
      tlc_if.btnCenter = 1'b0;
      tlc_if.vsync     = 1'b0;

      // ---- asynchronous reset between edges
      cyc(2);
      #2 reset_n = 1'b0;
      #1;
      check("rst_level", int'(tlc_if.level), 0);
      check("rst_upd", int'(tlc_if.levelUpdated), 0);
      @(negedge clock);
      reset_n = 1'b1;
      cyc(1);
      check("rst_atmin", int'(tlc_if.atMin), 0);
      check("rst_atmax", int'(tlc_if.atMax), 0);
      vsync_pulse(lvl, pulses);
      check("rst_vs_level", lvl, 0);
      check("rst_vs_pulses", pulses, 0);

      // ---- single one-cycle press
      tlc_if.btnUp = 1'b1;
      cyc(1);
      check("tap_not_yet", int'(dut.target), 0);
      tlc_if.btnUp = 1'b0;
      cyc(1);
      check("tap_target", int'(dut.target), 1);
      cyc(2);
      check("tap_idle", int'(dut.state), 0);
      check("tap_target_hold", int'(dut.target), 1);
      vsync_pulse(lvl, pulses);
      check("tap_level", lvl, 1);
      check("tap_pulses", pulses, 1);

      // ---- center restores reset level
      tlc_if.btnCenter = 1'b1;
      cyc(1);
      tlc_if.btnCenter = 1'b0;
      check("ctr_target", int'(dut.target), 0);
      vsync_pulse(lvl, pulses);
      check("ctr_level", lvl, 0);
      check("ctr_pulses", pulses, 1);

      // ---- hold with auto-repeat and acceleration up to the clamp
      tlc_if.btnUp = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cyc(1);
         check($sformatf("hold_t%0d", i + 1), int'(dut.target), hold_exp[i]);
      end
      check("hold_atmax", int'(tlc_if.atMax), 1);
      check("hold_atmin", int'(tlc_if.atMin), 0);
      vsync_pulse(lvl, pulses);
      check("hold_level", lvl, 20);
      check("hold_pulses", pulses, 1);
      tlc_if.btnUp = 1'b0;
      cyc(1);
      check("hold_release_idle", int'(dut.state), 0);

      // ---- step coinciding with a vsync edge
      tlc_if.btnDown = 1'b1;
      cyc(1);
      tlc_if.btnDown = 1'b0;
      cyc(3);
      check("coin_pre_target", int'(dut.target), 19);
      tlc_if.btnDown = 1'b1;
      cyc(1);                       // IDLE -> FIRST
      tlc_if.btnDown = 1'b0;
      tlc_if.vsync   = 1'b1;        // next edge both steps and commits
      cyc(1);
      check("coin_target", int'(dut.target), 18);
      check("coin_level", int'(tlc_if.level), 19);
      check("coin_upd", int'(tlc_if.levelUpdated), 1);
      cyc(3);                       // vsync held high: no new commit
      check("vs_high_level", int'(tlc_if.level), 19);
      check("vs_high_upd", int'(tlc_if.levelUpdated), 0);
      tlc_if.vsync = 1'b0;
      cyc(1);
      vsync_pulse(lvl, pulses);
      check("coin_next_level", lvl, 18);
      check("coin_next_pulses", pulses, 1);

      // ---- both buttons: no direction
      tlc_if.btnUp   = 1'b1;
      tlc_if.btnDown = 1'b1;
      cyc(3);
      check("both_idle", int'(dut.state), 0);
      check("both_target", int'(dut.target), 18);
      tlc_if.btnUp   = 1'b0;
      tlc_if.btnDown = 1'b0;
      cyc(1);

      // ---- hold down to the lower clamp, then center while still holding
      tlc_if.btnDown = 1'b1;
      cyc(24);
      check("down_target", int'(dut.target), -20);
      check("down_atmin", int'(tlc_if.atMin), 1);
      tlc_if.btnCenter = 1'b1;
      cyc(1);
      check("ctrhold_target", int'(dut.target), 0);
      check("ctrhold_atmin_lag", int'(tlc_if.atMin), 1);
      cyc(1);
      check("ctrhold_atmin", int'(tlc_if.atMin), 0);
      check("ctrhold_idle", int'(dut.state), 0);
      check("ctrhold_target2", int'(dut.target), 0);
      tlc_if.btnCenter = 1'b0;
      tlc_if.btnDown   = 1'b0;
      cyc(2);

      // ---- reset in the middle of a repeat
      tlc_if.btnUp = 1'b1;
      cyc(12);
      check("mid_target", int'(dut.target), 12);
      check("mid_state", int'(dut.state), 3);
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_level", int'(tlc_if.level), 0);
      check("mid_rst_target", int'(dut.target), 0);
      @(negedge clock);
      reset_n = 1'b1;
      cyc(1);
      check("mid_rel_target0", int'(dut.target), 0);
      check("mid_rel_first", int'(dut.state), 1);
      cyc(1);
      check("mid_rel_target1", int'(dut.target), 1);
      tlc_if.btnUp = 1'b0;
      cyc(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/trigger_level_controller.md
# trigger_level_controller

Sequences the oscilloscope trigger level from front-panel buttons and hands it to the trigger-level line sprite and trigger comparator. Single presses step the level by one code; holding a button auto-repeats and then accelerates. The level is clamped to a configured range. The value presented downstream changes only on a vsync rising edge, so the drawn line never tears mid-frame.

## Interface

Parameters:
- DATA_IN_BITS, 12, width of the signed level (matches the sample datapath)
- LEVEL_MIN, -384, lowest allowed level (signed)
- LEVEL_MAX, 383, highest allowed level (signed); LEVEL_MIN <= LEVEL_RESET <= LEVEL_MAX
- LEVEL_RESET, 0, level after reset and after a center press
- HOLD_DELAY, 25_000_000, cycles from the first step to the first auto-repeat step
- REPEAT_PERIOD, 5_000_000, cycles between auto-repeat steps
- FAST_AFTER, 8, number of slow repeat steps before switching to fast steps
- STEP_FAST, 8, step size in fast repeat (slow step is fixed at 1)

Ports:
- clock  in  1  system/pixel clock; all logic on posedge
- reset_n  in  1  asynchronous, active-low reset
- btnUp  in  1  level-sensitive, already debounced and synchronous to clock
- btnDown  in  1  same as btnUp, decrements
- btnCenter  in  1  same conditioning; restores LEVEL_RESET
- vsync  in  1  from VGA timing; a rising edge marks the frame boundary
- level  out  DATA_IN_BITS signed  committed level for sprite and trigger, registered
- levelUpdated  out  1  one-cycle pulse when level is loaded with a value different from its previous value
- atMin  out  1  registered; target == LEVEL_MIN
- atMax  out  1  registered; target == LEVEL_MAX

## Operation

- Internal signed `target` register has DATA_IN_BITS+1 bits. All step arithmetic is done at that width, then clamped to [LEVEL_MIN, LEVEL_MAX]. The result never wraps.
- Direction: up = btnUp & ~btnDown; down = btnDown & ~btnUp; both or neither = no direction.
- FSM states and transitions:
  - IDLE → FIRST when a direction is present. The direction is latched.
  - FIRST: applies a ±1 step this cycle, clears the counter, and goes to HOLD.
  - HOLD: counts to HOLD_DELAY. On reaching it, applies ±1, clears the repeat count, and goes to REPEAT.
  - REPEAT: applies a step every REPEAT_PERIOD cycles. The first FAST_AFTER steps are ±1; after that each step is ±STEP_FAST.
  - From HOLD or REPEAT, go to IDLE when the direction disappears or changes. Both buttons pressed counts as disappearing. Counters clear.
  - A changed direction re-enters FIRST on the following cycle from IDLE.
- btnCenter has priority over everything: target <= LEVEL_RESET and state <= IDLE every cycle it is high. Up/down are ignored until btnCenter is low and a fresh direction appears.
- Holding a button at a clamp limit keeps the FSM running, but target stays at the limit.
- Frame commit: vsyncPrev is registered. When vsync & ~vsyncPrev, level <= target as sampled that cycle, i.e. the pre-update value if a step occurs in the same cycle. levelUpdated asserts if the value changed.
- Reset (async, any time, including mid-hold):
  - level = target = LEVEL_RESET
  - state IDLE, all counters 0
  - vsyncPrev = 0
  - levelUpdated = 0
  - atMin/atMax reflect LEVEL_RESET from the first clock after release.

## Timing

- Press latency: a direction first sampled high at edge t gives target updated at edge t+1 (IDLE→FIRST at t, step in FIRST).
- First repeat step comes HOLD_DELAY cycles after the FIRST step. Subsequent steps are exactly REPEAT_PERIOD cycles apart.
- Release latency: 1 cycle to IDLE. No step is applied in the release cycle.
- level changes only on the clock edge that detects the vsync rising edge. level and levelUpdated are valid on the following cycle.
- A vsync held high without a new rising edge causes no further commits.
- atMin/atMax lag target by one cycle.

## Test plan

Bench parameters: HOLD_DELAY=4, REPEAT_PERIOD=2, FAST_AFTER=3, STEP_FAST=8, LEVEL_MIN=-20, LEVEL_MAX=20, LEVEL_RESET=0.

- Reset: pulse reset_n low asynchronously between clock edges → level=0, levelUpdated=0, atMin=atMax=0. Then a vsync edge → level stays 0 and no levelUpdated pulse.
- Single press: btnUp high for 1 cycle, then a vsync edge → target=1, level=1 after the edge, one levelUpdated pulse.
- Hold with acceleration: btnUp held 20 cycles → target sequence 1, 2 (+4 cycles), 3, 4 (every 2 cycles), then 12, 20 and clamped at 20. atMax=1, and the final commit gives level=20.
- Simultaneous events: a step lands in the same cycle as a vsync rising edge → level takes the pre-step target; the next vsync edge commits the new value.
- Conflicts: btnUp+btnDown together → no change, FSM in IDLE. btnCenter while holding btnDown at target=-20 → target=0, and atMin deasserts one cycle later.
- Reset mid-operation: assert reset_n low during REPEAT with target=12 → immediate level=0. After release, the button must be seen again in IDLE before any step is applied.
